// File: rtl/collision_scorer_pkg.sv
// Shared types and geometry for the object generator, scorer and renderer.
package collision_scorer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [8:0] ZONE_TOP_DEF  = 9'd390;
  localparam logic [8:0] ZONE_BOT_DEF  = 9'd420;
  localparam logic [8:0] NEW_PAIR_Y    = 9'd9;
  localparam logic [9:0] SCORE_MAX_DEF = 10'd999;

  // x origin of each lane, left pair then right pair
  localparam logic [9:0] LANE0_X = 10'd200;
  localparam logic [9:0] LANE1_X = 10'd260;
  localparam logic [9:0] LANE2_X = 10'd380;
  localparam logic [9:0] LANE3_X = 10'd440;

endpackage

// File: rtl/collision_scorer_lane_checker.sv
// Per-object hit evaluation: coin catch and fatal (obstacle hit or missed coin).
module lane_checker (
  input  logic zone,
  input  logic miss,
  input  logic square,
  input  logic match,
  input  logic caught,
  output logic coin_catch,
  output logic fatal
);

  assign coin_catch = zone && !square && match && !caught;

  // a coin that leaves the zone uncaught ends the game
  assign fatal = (zone && square && match) ||
                 (miss && !square && !caught);

endmodule

// File: rtl/collision_scorer.sv
// Game FSM, per-pair catch flags and score / high-score bookkeeping.
module collision_scorer
  import collision_scorer_pkg::*;
#(
  parameter logic [8:0] ZONE_TOP  = ZONE_TOP_DEF,
  parameter logic [8:0] ZONE_BOT  = ZONE_BOT_DEF,
  parameter logic [9:0] SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic       pix_stb1,
  input  logic       RST,
  input  logic       start,
  input  logic       object_generated,
  input  logic [8:0] object_y,
  input  logic       object_is_square,
  input  logic       object_is_square2,
  input  logic       path,
  input  logic       path2,
  input  logic       car_path,
  input  logic       car_path2,
  output logic       active,
  output logic       end_game,
  output logic [9:0] score,
  output logic [9:0] high_score
);

  state_t state;
  logic caught1, caught2;
  logic in_zone, miss_row, new_pair;
  logic catch1, catch2, fatal1, fatal2;
  logic fatal;
  logic [10:0] sum;
  logic [9:0]  next_score;

  assign in_zone  = object_generated &&
                    object_y >= ZONE_TOP &&
                    object_y <= ZONE_BOT;
  assign miss_row = object_generated &&
                    object_y == ZONE_BOT + 9'd1;
  assign new_pair = object_y == NEW_PAIR_Y;

  lane_checker u_left (
    .zone       (in_zone),
    .miss       (miss_row),
    .square     (object_is_square),
    .match      (path == car_path),
    .caught     (caught1),
    .coin_catch (catch1),
    .fatal      (fatal1)
  );

  lane_checker u_right (
    .zone       (in_zone),
    .miss       (miss_row),
    .square     (object_is_square2),
    .match      (path2 == car_path2),
    .caught     (caught2),
    .coin_catch (catch2),
    .fatal      (fatal2)
  );

  assign fatal = fatal1 || fatal2;

  assign sum = {1'b0, score} +
               {10'd0, catch1} +
               {10'd0, catch2};

  assign next_score = (sum > {1'b0, SCORE_MAX}) ?
                      SCORE_MAX : sum[9:0];

  always_ff @(posedge pix_stb1) begin
    if (RST) begin
      state      <= ST_IDLE;
      score      <= 10'd0;
      high_score <= 10'd0;
      caught1    <= 1'b0;
      caught2    <= 1'b0;
      active     <= 1'b0;
      end_game   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state    <= ST_PLAY;
            active   <= 1'b1;
            end_game <= 1'b0;
            score    <= 10'd0;
            caught1  <= 1'b0;
            caught2  <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (fatal) begin
            state    <= ST_OVER;
            active   <= 1'b0;
            end_game <= 1'b1;
            if (score > high_score)
              high_score <= score;
          end else begin
            score <= next_score;
          end
          if (new_pair) begin
            caught1 <= 1'b0;
            caught2 <= 1'b0;
          end else begin
            if (catch1) caught1 <= 1'b1;
            if (catch2) caught2 <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          active   <= 1'b0;
          end_game <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/collision_scorer.md
COLLISION_SCORER -- requirements
Module: collision_scorer

Interface
REQ-001 Parameter ZONE_TOP, default 9'd390: first object_y row of the car hit zone.
REQ-002 Parameter ZONE_BOT, default 9'd420: last object_y row of the car hit zone.
REQ-003 Parameter SCORE_MAX, default 10'd999: score saturation value.
REQ-004 pix_stb1  in  1  single clock; all state changes on its rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin or restart a game.
REQ-007 object_generated  in  1  object pair valid, from object generator.
REQ-008 object_y  in  9  shared y of both objects.
REQ-009 object_is_square / object_is_square2  in  1 each  1 = obstacle, 0 = coin; left / right pair.
REQ-010 path / path2  in  1 each  lane of left / right object.
REQ-011 car_path / car_path2  in  1 each  lane of left / right car.
REQ-012 active  out  1  game running; drives generator active.
REQ-013 end_game  out  1  game over, level, registered.
REQ-014 score  out  10  coins caught this game, binary.
REQ-015 high_score  out  10  best score since RST.

Function
REQ-016 FSM states IDLE, PLAY, OVER; active = (state==PLAY); end_game = (state==OVER).
REQ-017 IDLE->PLAY on start; score cleared to 0 on that edge.
REQ-018 PLAY->OVER on any fatal event (REQ-021, REQ-022); OVER->PLAY on start, score cleared to 0; start in PLAY ignored.
REQ-019 In zone = object_generated && ZONE_TOP <= object_y <= ZONE_BOT; left match = path==car_path, right match = path2==car_path2.
REQ-020 Per-object flags caught1/caught2 clear on every cycle with object_y==9 (new pair), set when the corresponding coin is caught.
REQ-021 Square in zone with lane match = fatal, same cycle evaluation, transition on next edge.
REQ-022 Coin not caught when object_y == ZONE_BOT+1 with object_generated = fatal (missed coin).
REQ-023 Coin in zone, lane match, flag clear: score +1, flag set; each object counts at most once.
REQ-024 Both coins caught in same cycle: score +2.
REQ-025 Fatal and catch in same cycle: fatal wins, score unchanged.
REQ-026 Score saturates at SCORE_MAX; no wrap.
REQ-027 On PLAY->OVER edge, high_score <= max(high_score, final score incl. no increment that cycle); score holds through OVER.
REQ-028 Inputs sampled only in PLAY; object inputs ignored in IDLE and OVER.
REQ-029 Latency: event at cycle N visible on outputs at edge N+1.

Reset
REQ-030 RST high at edge: state=IDLE, score=0, high_score=0, caught1=caught2=0, active=0, end_game=0.
REQ-031 RST overrides start and all events in the same cycle, including mid-game.

Structure
REQ-032 Shared package holds FSM state encoding, ZONE_TOP/ZONE_BOT defaults and lane x constants common to generator, scorer and renderer.
REQ-033 One sub-module lane_checker (instantiated twice): inputs zone, square, lane match, caught flag; outputs catch and fatal pulses.
REQ-034 Score/high_score arithmetic and FSM in top level; no other submodules.

Verification
REQ-035 RST, start, left coin path=0 car_path=0 sweeping y 9..421 -> score=1 at y=391 edge, stays 1, no end_game.
REQ-036 Left square path=1 car_path=1, y reaches 390 -> end_game=1, active=0 next edge, score unchanged.
REQ-037 Left coin path=1 car_path=0 to y=421 -> end_game=1; high_score updated to prior score.
REQ-038 Both coins matched, both in zone same cycle -> score +2 in one edge.
REQ-039 Square fatal and right coin catch same cycle -> end_game=1, score unchanged; then start -> PLAY, score=0, high_score retained.
REQ-040 Score preloaded to 999 by repeated catches, one more catch -> score=999; RST mid-PLAY -> IDLE, score=0, high_score=0.
